// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader: frame-state encoding and the default
// memory-port widths used by the loader, the top-level memory mux and the bench.
package boot_pkg;

  localparam int BOOT_DATA_W = 8;
  localparam int BOOT_ADDR_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } boot_state_t;

endpackage

// File: rtl/boot_timeout.sv
// Idle-cycle watchdog for the payload phase. Counts enabled cycles, reloads to
// zero on clr, and flags expire on the cycle that would reach TIMEOUT_CYC.
// TIMEOUT_CYC = 0 removes the counter and ties expire low.
module boot_timeout #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      logic unused_in;
      assign unused_in = ^{clk, rst, clr, en};
      assign expire    = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT_CYC + 1);
      logic [CW-1:0] idle_cnt;

      // Idle counter: restart on clr, otherwise count enabled cycles.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          idle_cnt <= '0;
        end else if (clr) begin
          idle_cnt <= '0;
        end else if (en) begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end

      assign expire = en && (idle_cnt == CW'(TIMEOUT_CYC - 1));
    end
  endgenerate

endmodule

// File: rtl/boot_loader.sv
// Boot loader: receives a framed byte stream (LEN, ADDR, payload[, CSUM]) and
// writes the payload into program memory, holding the CPU until the image is
// complete. Optional build macro BOOT_CHECKSUM_EN adds a trailing checksum byte
// (LEN + ADDR + payload, modulo 2**DATA_W) that must match before release.
module boot_loader
  import boot_pkg::*;
#(
  parameter int DATA_W      = BOOT_DATA_W,
  parameter int ADDR_W      = BOOT_ADDR_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] mem_din,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              bus_own,
  output logic              cpu_run,
  output logic              busy,
  output logic              err
);

  boot_state_t       state, state_nxt;
  logic [ADDR_W:0]   remain;
  logic [ADDR_W-1:0] ptr;
  logic              accept;
  logic              last_byte;
  logic              expire;
  logic              reload;

  assign in_ready  = (state == ST_LEN) || (state == ST_ADDR) ||
                     (state == ST_DATA) || (state == ST_CSUM);
  assign busy      = in_ready;
  assign accept    = in_valid && in_ready;
  assign last_byte = (remain == (ADDR_W + 1)'(1));
  assign bus_own   = busy || mem_we;
  assign reload    = load && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));

`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_t ST_AFTER_DATA = ST_CSUM;
  logic [DATA_W-1:0] sum;

  // Running checksum over LEN, ADDR and every payload byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
    end else if (accept) begin
      if (state == ST_LEN) begin
        sum <= in_data;
      end else if ((state == ST_ADDR) || (state == ST_DATA)) begin
        sum <= sum + in_data;
      end
    end
  end
`else
  localparam boot_state_t ST_AFTER_DATA = ST_DONE;
`endif

  boot_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    ((state != ST_DATA) || accept),
    .en     ((state == ST_DATA) && !accept),
    .expire (expire)
  );

  // Frame state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; load is only honoured outside a frame.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (reload) state_nxt = ST_LEN;
      end
      ST_LEN: begin
        if (accept) state_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        if (accept) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (accept) begin
          if (last_byte) state_nxt = ST_AFTER_DATA;
        end else if (expire) begin
          state_nxt = ST_ERR;
        end
      end
`ifdef BOOT_CHECKSUM_EN
      ST_CSUM: begin
        if (accept) state_nxt = (in_data == sum) ? ST_DONE : ST_ERR;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Byte counter, write pointer, memory write port and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remain   <= '0;
      ptr      <= '0;
      mem_din  <= '0;
      mem_addr <= '0;
      mem_we   <= 1'b0;
      cpu_run  <= 1'b0;
      err      <= 1'b0;
    end else begin
      mem_we  <= 1'b0;
      // Release one cycle after DONE is entered, i.e. after the final write.
      cpu_run <= (state == ST_DONE) && !load;
      if ((state_nxt == ST_ERR) && (state != ST_ERR)) begin
        err <= 1'b1;
      end else if (reload) begin
        err <= 1'b0;
      end
      if (accept) begin
        case (state)
          ST_LEN: begin
            remain <= (in_data == '0) ? {1'b1, {ADDR_W{1'b0}}} : (ADDR_W + 1)'(in_data);
          end
          ST_ADDR: begin
            ptr <= ADDR_W'(in_data);
          end
          ST_DATA: begin
            mem_din  <= in_data;
            mem_addr <= ptr;
            mem_we   <= 1'b1;
            ptr      <= ptr + 1'b1;
            remain   <= remain - 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
